// File: rtl/timer_pkg.sv
// Shared types for the countdown timer and the control FSMs that watch its busy flag.
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/timer_countdown.sv
// Programmable countdown timer: counts accepted ce ticks after a start and
// emits a one-cycle done pulse on expiry, either one-shot or auto-reload.
//
// state | meaning
// IDLE  | not counting; count holds, ce ignored
// RUN   | counting down on ce; count is always >= 1 here
module timer_countdown
    import timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    timer_state_t     r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_mode;
    logic             r_done;

    timer_state_t     w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_mode_nxt;
    logic             w_done_nxt;

    // Next-state and next-output decode; stop beats start beats ce.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_mode_nxt   = r_mode;
        w_done_nxt   = 1'b0;

        if (stop) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
        end else if (start) begin
            if (load_val != '0) begin
                w_state_nxt  = RUN;
                w_count_nxt  = load_val;
                w_reload_nxt = load_val;
                w_mode_nxt   = auto_reload;
            end else begin
                // Zero period expires immediately instead of entering RUN.
                w_state_nxt = IDLE;
                w_count_nxt = '0;
                w_done_nxt  = 1'b1;
            end
        end else if ((r_state == RUN) && ce) begin
            if (r_count > WIDTH'(1)) begin
                w_count_nxt = r_count - WIDTH'(1);
            end else begin
                w_done_nxt = 1'b1;
                if (r_mode) begin
                    // Reload directly from 1 so periodic mode never shows 0.
                    w_count_nxt = r_reload;
                end else begin
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_mode   <= w_mode_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign count = r_count;
    assign busy  = (r_state == RUN);
    assign done  = r_done;

endmodule

// File: tb/tb_timer_countdown.sv
// Scoreboard bench for timer_countdown: a 16-bit and a 2-bit instance share
// control inputs; an elapsed-tick reference model predicts their outputs.
module tb_timer_countdown;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        auto_reload = 1'b0;
    logic [15:0] load_val = '0;
    logic [1:0]  load_val2;
    logic [15:0] count0;
    logic [1:0]  count1;
    logic        busy0, busy1, done0, done1;

    assign load_val2 = load_val[1:0];

    timer_countdown #(.WIDTH(16)) u_dut0 (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .stop(stop),
        .load_val(load_val), .auto_reload(auto_reload),
        .count(count0), .busy(busy0), .done(done0)
    );

    timer_countdown #(.WIDTH(2)) u_dut1 (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .stop(stop),
        .load_val(load_val2), .auto_reload(auto_reload),
        .count(count1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    // Reference: a timer is either running or not; while running it knows its
    // period and how many ticks have elapsed since start. Remaining count is
    // period minus elapsed-mod-period; an idle timer always reads 0.
    typedef struct {
        bit run;
        int period;
        bit periodic;
        int ticks;
    } model_t;

    typedef struct {
        int count;
        bit busy;
        bit done;
    } exp_t;

    model_t m0, m1;
    exp_t   q0[$];
    exp_t   q1[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc_no = 0;

    function automatic void model_reset(output model_t m);
        m.run = 0; m.period = 0; m.periodic = 0; m.ticks = 0;
    endfunction

    function automatic void model_step(inout model_t m, input bit sp, input bit st,
                                       input int lv, input bit ar, input bit c,
                                       output bit dn);
        dn = 0;
        if (sp) begin
            m.run = 0;
        end else if (st) begin
            if (lv == 0) begin
                dn = 1;
                m.run = 0;
            end else begin
                m.run = 1; m.period = lv; m.periodic = ar; m.ticks = 0;
            end
        end else if (m.run && c) begin
            m.ticks++;
            if (m.ticks % m.period == 0) begin
                dn = 1;
                if (!m.periodic) m.run = 0;
            end
        end
    endfunction

    function automatic exp_t model_out(input model_t m, input bit dn);
        exp_t e;
        e.count = m.run ? (m.period - (m.ticks % m.period)) : 0;
        e.busy  = m.run;
        e.done  = dn;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc_no, act, exp);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, predict, enqueue.
    task automatic cyc(input bit st, input bit sp, input int lv, input bit ar, input bit c);
        bit d0, d1;
        @(negedge clk);
        rst = 1'b0;
        start = st; stop = sp; load_val = 16'(lv); auto_reload = ar; ce = c;
        model_step(m0, sp, st, lv & 16'hffff, ar, c, d0);
        model_step(m1, sp, st, lv & 3, ar, c, d1);
        q0.push_back(model_out(m0, d0));
        q1.push_back(model_out(m1, d1));
    endtask

    // Reset asserted between edges must clear outputs without waiting for clk.
    task automatic async_reset();
        @(negedge clk);
        start = 0; stop = 0; ce = 1;
        #2 rst = 1'b1;
        #1;
        check("async_rst_count0", int'(count0), 0);
        check("async_rst_busy0", int'(busy0), 0);
        check("async_rst_done0", int'(done0), 0);
        check("async_rst_count1", int'(count1), 0);
        model_reset(m0);
        model_reset(m1);
        q0.push_back(model_out(m0, 0));
        q1.push_back(model_out(m1, 0));
    endtask

    // Monitor: outputs are presented every cycle; compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("count_w16", int'(count0), e.count);
                check("busy_w16", int'(busy0), int'(e.busy));
                check("done_w16", int'(done0), int'(e.done));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("count_w2", int'(count1), e.count);
                check("busy_w2", int'(busy1), int'(e.busy));
                check("done_w2", int'(done1), int'(e.done));
            end
        end
    end

    initial begin
        bit d;
        model_reset(m0);
        model_reset(m1);
        // Held reset: outputs at reset values.
        repeat (2) begin
            @(negedge clk);
            q0.push_back(model_out(m0, 0));
            q1.push_back(model_out(m1, 0));
        end

        // One-shot N=5 with ce always high.
        cyc(1, 0, 5, 0, 1);
        repeat (7) cyc(0, 0, 0, 0, 1);

        // Auto-reload N=3, ce every second cycle.
        cyc(1, 0, 3, 1, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, (i % 2) == 1);
        cyc(0, 1, 0, 0, 0);

        // Stop with count at 2, then ticks must do nothing.
        cyc(1, 0, 4, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);

        // Restart at count 1 coinciding with a tick, then start+stop together.
        cyc(1, 0, 4, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 7, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 9, 1, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);

        // Stop coinciding with expiry in periodic mode.
        cyc(1, 0, 2, 1, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Zero period; lv=3 fits both widths; lv=4 is zero for the 2-bit timer.
        cyc(1, 0, 0, 1, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 3, 0, 1);
        repeat (5) cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 4, 0, 1);
        repeat (6) cyc(0, 0, 0, 0, 1);

        // Asynchronous reset mid-run at count 10.
        cyc(1, 0, 20, 1, 0);
        repeat (10) cyc(0, 0, 0, 0, 1);
        async_reset();
        repeat (6) cyc(0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            int lv;
            r  = int'($urandom_range(0, 99));
            lv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 14));
            cyc(r >= 3 && r < 10, r < 3, lv, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 499) == 0);
            if (d) async_reset();
        end

        cyc(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
